// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants, state encoding and FIFO entry layout for the instruction-fetch sequencer.
// The address-legality rule lives here so every user applies the same bounds.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEF   = 4096;
    localparam int unsigned FIFO_DEPTH_DEF = 2;
    localparam logic [31:0] NOP            = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // The upper bound is widened to 33 bits so a window ending at 2^32 still compares correctly.
    function automatic logic addr_bad(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input int unsigned words);
        logic [32:0] limit;
        limit = {1'b0, base} + (33'(words) << 2);
        return (pc[1:0] != 2'b00) | (pc < base) | ({1'b0, pc} >= limit);
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// Synchronous fetch queue with a registered head.
// The head holds its last value when the queue drains or is flushed.
module fetch_fifo
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     dout_q, dout_d;
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             pop_eff, push_eff;

    always_comb begin
        pop_eff  = pop & (cnt_q != '0);
        push_eff = push & ~flush & ((cnt_q < FULL) | pop_eff);
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop_eff)  rd_d = rd_q + 1'b1;
            if (push_eff) wr_d = wr_q + 1'b1;
            cnt_d = cnt_q + (PTR_W + 1)'(push_eff) - (PTR_W + 1)'(pop_eff);
            // Preload next cycle's head, bypassing storage when the new head is being written now.
            if (cnt_d != '0) begin
                dout_d = (push_eff && (rd_d == wr_q)) ? din : mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_q] <= din;
    end

    assign dout  = dout_q;
    assign count = cnt_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, queues {pc, instr, adel} for decode,
// absorbs stalls, follows redirects and parks in FAULT after fetching an illegal address.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE    = IM_BASE_DEF,
    parameter int unsigned IM_WORDS   = IM_WORDS_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_adel
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    fetch_state_e     state_q, state_d;
    logic             bad, room, pop, push;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_din, fifo_dout;

    assign bad       = addr_bad(pc_q, IM_BASE, IM_WORDS);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign room      = (fifo_count < FULL) | pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // A redirect wins over fetching and also flushes the queue through the FIFO's flush input.
    always_comb begin
        pc_d           = pc_q;
        state_d        = state_q;
        push           = 1'b0;
        fifo_din.adel  = bad;
        fifo_din.pc    = pc_q;
        fifo_din.instr = bad ? NOP : im_instr;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && room) begin
            push = 1'b1;
            if (bad) begin
                state_d = ST_FAULT;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign im_pc     = pc_q;
    assign out_instr = fifo_dout.instr;
    assign out_pc    = fifo_dout.pc;
    assign out_adel  = fifo_dout.adel;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: a fixed vector table, hand-written corner sequences
// and a randomized run, all compared against a queue-based model of the fetch stream.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_END   = 32'h0000_7000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imPc;
    logic [31:0] imInstr;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstr;
    logic [31:0] outPc;
    logic        outAdel;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;

    entry_t      mQ[$];
    entry_t      mLast;
    logic [31:0] mPc;
    logic        mFault;

    typedef struct {
        logic        ready;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expImPc;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    function automatic logic isBad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < IM_BASE) || (a >= IM_END);
    endfunction

    function automatic logic [31:0] imWord(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - IM_BASE) >> 2;
        return (idx * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory contents for legal words; illegal addresses return nonzero garbage that must be masked.
    assign imInstr = isBad(imPc) ? (32'hBAD0_0000 | imPc) : imWord(imPc);

    if_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .im_pc          (imPc),
        .im_instr       (imInstr),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .out_valid      (outValid),
        .out_ready      (outReady),
        .out_instr      (outInstr),
        .out_pc         (outPc),
        .out_adel       (outAdel)
    );

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Compare the DUT's current outputs against the model's view of the queue head.
    task automatic checkOutput();
        checkEq("im_pc", imPc, mPc);
        checkEq("out_valid", 32'(outValid), 32'(mQ.size() != 0));
        if (mQ.size() != 0) begin
            checkEq("head_pc", outPc, mQ[0].pc);
            checkEq("head_instr", outInstr, mQ[0].instr);
            checkEq("head_adel", 32'(outAdel), 32'(mQ[0].adel));
        end else begin
            checkEq("hold_pc", outPc, mLast.pc);
            checkEq("hold_instr", outInstr, mLast.instr);
            checkEq("hold_adel", 32'(outAdel), 32'(mLast.adel));
        end
    endtask

    // Drive inputs for the coming edge and advance the model by that edge.
    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc,
                                 input logic rst);
        entry_t e;
        outReady      = rdy;
        redirectValid = rv;
        redirectPc    = rpc;
        reset         = rst;
        if (rst) begin
            mQ.delete();
            mPc    = RESET_PC;
            mFault = 1'b0;
            mLast  = '{pc: 32'h0, instr: 32'h0, adel: 1'b0};
            return;
        end
        if (mQ.size() != 0) begin
            mLast = mQ[0];
            if (rdy) void'(mQ.pop_front());
        end
        if (rv) begin
            mQ.delete();
            mPc    = rpc;
            mFault = 1'b0;
        end else if (!mFault && mQ.size() < DEPTH) begin
            e.pc    = mPc;
            e.adel  = isBad(mPc);
            e.instr = e.adel ? 32'h0 : imWord(mPc);
            mQ.push_back(e);
            if (e.adel) mFault = 1'b1;
            else        mPc    = mPc + 32'd4;
        end
    endtask

    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rst);
        checkOutput();
        applyStimulus(rdy, rv, rpc, rst);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] randomTarget();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0: a = IM_BASE + 32'($urandom_range(0, 4095)) * 4;
            1: a = 32'h0000_6FF0 + 32'($urandom_range(0, 3)) * 4;
            2: a = IM_BASE + 32'($urandom_range(0, 4095)) * 4 + 32'($urandom_range(1, 3));
            3: a = 32'h0000_2FFC;
            4: a = ($urandom_range(0, 1) != 0) ? IM_END : 32'hFFFF_FFFC;
            default: a = IM_BASE;
        endcase
        return a;
    endfunction

    initial begin
        vecs[0] = '{ready: 1'b0, expValid: 1'b0, expPc: 32'h0,    expImPc: 32'h3000};
        vecs[1] = '{ready: 1'b0, expValid: 1'b1, expPc: 32'h3000, expImPc: 32'h3004};
        vecs[2] = '{ready: 1'b0, expValid: 1'b1, expPc: 32'h3000, expImPc: 32'h3008};
        vecs[3] = '{ready: 1'b0, expValid: 1'b1, expPc: 32'h3000, expImPc: 32'h3008};
        vecs[4] = '{ready: 1'b0, expValid: 1'b1, expPc: 32'h3000, expImPc: 32'h3008};
        vecs[5] = '{ready: 1'b1, expValid: 1'b1, expPc: 32'h3000, expImPc: 32'h3008};
        vecs[6] = '{ready: 1'b1, expValid: 1'b1, expPc: 32'h3004, expImPc: 32'h300C};
        vecs[7] = '{ready: 1'b1, expValid: 1'b1, expPc: 32'h3008, expImPc: 32'h3010};
        vecs[8] = '{ready: 1'b1, expValid: 1'b1, expPc: 32'h300C, expImPc: 32'h3014};
        vecs[9] = '{ready: 1'b1, expValid: 1'b1, expPc: 32'h3010, expImPc: 32'h3018};

        outReady      = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        reset         = 1'b1;
        mQ.delete();
        mPc    = RESET_PC;
        mFault = 1'b0;
        mLast  = '{pc: 32'h0, instr: 32'h0, adel: 1'b0};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] vector table: fill, stall and drain");
        for (int i = 0; i < 10; i++) begin
            checkEq("tbl_valid", 32'(outValid), 32'(vecs[i].expValid));
            checkEq("tbl_im_pc", imPc, vecs[i].expImPc);
            checkEq("tbl_out_pc", outPc, vecs[i].expPc);
            if (vecs[i].expValid) checkEq("tbl_out_instr", outInstr, imWord(vecs[i].expPc));
            cycle(vecs[i].ready, 1'b0, 32'h0, 1'b0);
        end

        $display("[TB] redirect while full");
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h3100, 1'b0);
        checkEq("rd_valid", 32'(outValid), 32'h0);
        checkEq("rd_im_pc", imPc, 32'h3100);
        checkEq("rd_hold_pc", outPc, 32'h3014);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("rd_head_pc", outPc, 32'h3100);
        checkEq("rd_head_instr", outInstr, imWord(32'h3100));

        $display("[TB] misaligned redirect faults");
        cycle(1'b1, 1'b1, 32'h3102, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("mis_valid", 32'(outValid), 32'h1);
        checkEq("mis_pc", outPc, 32'h3102);
        checkEq("mis_adel", 32'(outAdel), 32'h1);
        checkEq("mis_instr", outInstr, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("fault_valid", 32'(outValid), 32'h0);
        checkEq("fault_im_pc", imPc, 32'h3102);

        $display("[TB] end of instruction memory");
        cycle(1'b1, 1'b1, 32'h6FFC, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("last_pc", outPc, 32'h6FFC);
        checkEq("last_adel", 32'(outAdel), 32'h0);
        checkEq("last_instr", outInstr, imWord(32'h6FFC));
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("oor_pc", outPc, 32'h7000);
        checkEq("oor_adel", 32'(outAdel), 32'h1);
        checkEq("oor_instr", outInstr, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("oor_valid", 32'(outValid), 32'h0);
        checkEq("oor_im_pc", imPc, 32'h7000);

        $display("[TB] reset with a full queue");
        cycle(1'b1, 1'b1, 32'h3000, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        checkEq("rst_valid", 32'(outValid), 32'h0);
        checkEq("rst_im_pc", imPc, 32'h3000);
        checkEq("rst_out_pc", outPc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("rst_head_pc", outPc, 32'h3000);
        checkEq("rst_head_instr", outInstr, imWord(32'h3000));

        $display("[TB] randomized run");
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0,
                  randomTarget(),
                  $urandom_range(0, 199) == 0);
        end
        checkOutput();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
